// File: rtl/fifo_pkg.sv
// Definitions shared by the 8-bit synchronous FIFO, its write-side producer
// and the read-side consumer: data width, counter width and occupancy codes.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Number of words represented by an occupancy code, widened for arithmetic.
    function automatic logic [2:0] occ_words(input occ_e occ);
        return {1'b0, occ};
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready port of the FIFO reader.
// master = the reader itself, slave = FIFO and sink side.
interface fifo_reader_if #(
    parameter int DATA_W = fifo_pkg::DATA_W
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  data_ready,
        output rd_en,
        output data_out,
        output data_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output data_ready,
        input  rd_en,
        input  data_out,
        input  data_valid
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry register buffer with push/pop/flush; head word is always in r_head,
// the second word (when FULL) in r_tail, so the head never moves while stalled.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int W = fifo_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output occ_e         o_occ,
    output logic [W-1:0] o_head,
    output logic         o_valid
);

    occ_e         r_occ;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_occ <= OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (i_push) begin
                        r_head <= i_data;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (i_push && i_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail <= i_data;
                        r_occ  <= OCC_FULL;
                    end else if (i_pop) begin
                        r_occ <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // A push while FULL can only coincide with a pop (rd_en throttling).
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_data;
                        end else begin
                            r_occ <= OCC_ONE;
                        end
                    end
                end
                default: r_occ <= OCC_EMPTY;
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_head  = r_head;
    assign o_valid = (r_occ != OCC_EMPTY);

endmodule

// File: rtl/fifo_reader.sv
// Read-side consumer of the synchronous FIFO: issues rd_en, absorbs the 1-cycle
// read latency through an in-flight flag, and counts delivered words.
module fifo_reader #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = fifo_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic [CNT_W-1:0] rd_count,
    fifo_reader_if.master    bus
);
    import fifo_pkg::*;

    logic              r_inflight;
    logic [CNT_W-1:0]  r_rd_count;

    occ_e              w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_valid;
    logic              w_pop;
    logic              w_rd_en;
    logic [2:0]        w_need;
    logic [2:0]        w_limit;

    assign w_pop = w_valid && bus.data_ready;

    // occ + inflight - pop <= 1, rearranged to stay unsigned.
    assign w_need  = occ_words(w_occ) + {2'b00, r_inflight};
    assign w_limit = 3'd1 + {2'b00, w_pop};
    assign w_rd_en = rst && !flush && !bus.fifo_empty && (w_need <= w_limit);

    fifo_rd_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (bus.fifo_data),
        .o_occ   (w_occ),
        .o_head  (w_head),
        .o_valid (w_valid)
    );

    // rd_en is forced low during flush, so inflight clears and the word it
    // would have tagged is never pushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_rd_count <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

    assign bus.rd_en      = w_rd_en;
    assign bus.data_out   = w_head;
    assign bus.data_valid = w_valid;
    assign rd_count       = r_rd_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a model FIFO with 1-cycle read latency feeds
// the DUT, a monitor process pops expected words and compares every transfer.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int MEM_N = 70000;

    typedef struct packed {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] rd_count;

    fifo_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_reader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rd_count (rd_count),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model FIFO: registered read data valid the cycle after rd_en.
    logic [DATA_W-1:0] mem [0:MEM_N-1];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    exp_t             exp_q[$];
    int               checks  = 0;
    int               errors  = 0;
    bit               verbose = 1'b1;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               xfer_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr] = d;
        exp_q.push_back('{idx: wr_ptr, data: d});
        wr_ptr++;
    endtask

    // Words already read from the FIFO but not delivered are discarded by flush/reset.
    task automatic trim_exp();
        while (exp_q.size() > 0 && exp_q[0].idx < rd_ptr) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic monitor();
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (prev_hold && bus.data_valid) begin
                    check("hold_stable", 32'(bus.data_out), 32'(prev_data));
                end
                if (bus.data_valid && bus.data_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got %02h required none", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        xfer_n++;
                        if (verbose) begin
                            $display("XFER %0d idx=%0d data=%02h exp=%02h rd_count=%0d",
                                     xfer_n, e.idx, bus.data_out, e.data, rd_count);
                        end
                        check("xfer_data", 32'(bus.data_out), 32'(e.data));
                    end
                    exp_cnt = exp_cnt + CNT_W'(1);
                end
            end else begin
                exp_cnt = '0;
            end
            prev_hold = rst && !flush && bus.data_valid && !bus.data_ready;
            prev_data = bus.data_out;
        end
    endtask

    // Samples n cycles 2 time units after each falling edge.
    task automatic observe(input int n, output int rd_n, output int first_rd, output int first_v,
                           output int x_n, output int first_x, output int last_x);
        rd_n = 0; first_rd = -1; first_v = -1; x_n = 0; first_x = -1; last_x = -1;
        for (int c = 0; c < n; c++) begin
            #2;
            if (bus.rd_en) begin
                rd_n++;
                if (first_rd < 0) first_rd = c;
            end
            if (bus.data_valid && first_v < 0) first_v = c;
            if (bus.data_valid && bus.data_ready) begin
                if (first_x < 0) first_x = c;
                last_x = c;
                x_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic stimulus();
        int               rd_n, first_rd, first_v, x_n, first_x, last_x, n;
        logic [CNT_W-1:0] cnt_snap;

        // Reset with three words waiting in the FIFO.
        rst = 1'b0;
        flush = 1'b0;
        bus.data_ready = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        repeat (3) @(negedge clk);
        #2;
        check("reset_rd_en", 32'(bus.rd_en), 32'd0);
        check("reset_valid", 32'(bus.data_valid), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        check("reset_rd_count", 32'(rd_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        observe(10, rd_n, first_rd, first_v, x_n, first_x, last_x);
        check("p1_rd_en_cycles", 32'(rd_n), 32'd3);
        check("p1_latency", 32'(first_v - first_rd), 32'd2);
        check("p1_xfers", 32'(x_n), 32'd3);
        check("p1_no_gaps", 32'(last_x - first_x), 32'd2);
        check("p1_rd_count", 32'(rd_count), 32'd3);

        // Backpressure: only two words may be pulled.
        bus.data_ready = 1'b0;
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        push_word(8'h44);
        observe(8, rd_n, first_rd, first_v, x_n, first_x, last_x);
        check("p2_rd_en_cycles", 32'(rd_n), 32'd2);
        #2;
        check("p2_valid", 32'(bus.data_valid), 32'd1);
        check("p2_head", 32'(bus.data_out), 32'h41);
        @(negedge clk);
        bus.data_ready = 1'b1;
        observe(8, rd_n, first_rd, first_v, x_n, first_x, last_x);
        check("p2_xfers", 32'(x_n), 32'd4);
        check("p2_first_xfer", 32'(first_x), 32'd0);
        check("p2_no_gaps", 32'(last_x - first_x), 32'd3);
        check("p2_rd_count", 32'(rd_count), 32'd7);

        // Flush while one word is buffered and the next is in flight.
        bus.data_ready = 1'b0;
        push_word(8'h51);
        push_word(8'h52);
        push_word(8'h53);
        push_word(8'h54);
        push_word(8'h55);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #2;
        check("p3_pre_valid", 32'(bus.data_valid), 32'd1);
        check("p3_pre_head", 32'(bus.data_out), 32'h51);
        check("p3_flush_rd_en", 32'(bus.rd_en), 32'd0);
        cnt_snap = rd_count;
        @(negedge clk);
        flush = 1'b0;
        trim_exp();
        #2;
        check("p3_valid_after", 32'(bus.data_valid), 32'd0);
        check("p3_resume_rd_en", 32'(bus.rd_en), 32'd1);
        check("p3_rd_count_kept", 32'(rd_count), 32'(cnt_snap));
        @(negedge clk);
        #2;
        check("p3_drop_inflight", 32'(bus.data_valid), 32'd0);
        @(negedge clk);
        bus.data_ready = 1'b1;
        observe(10, rd_n, first_rd, first_v, x_n, first_x, last_x);
        check("p3_xfers", 32'(x_n), 32'd3);
        check("p3_rd_count", 32'(rd_count), 32'd10);

        // Reset mid-stream with one word buffered and one in flight.
        bus.data_ready = 1'b0;
        push_word(8'h61);
        push_word(8'h62);
        repeat (2) @(negedge clk);
        #2;
        check("p4_pre_valid", 32'(bus.data_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("p4_rst_rd_en", 32'(bus.rd_en), 32'd0);
        @(negedge clk);
        #2;
        check("p4_data_out", 32'(bus.data_out), 32'd0);
        check("p4_valid", 32'(bus.data_valid), 32'd0);
        check("p4_rd_count", 32'(rd_count), 32'd0);
        check("p4_rd_en", 32'(bus.rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        trim_exp();

        // Counter wrap: 65535 words, then one more.
        verbose = 1'b0;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            push_word(8'(i) ^ 8'h5A);
        end
        wait_drain(70000);
        check("p5_rd_count_max", 32'(rd_count), 32'h0000FFFF);
        check("p5_model_count", 32'(rd_count), 32'(exp_cnt));
        verbose = 1'b1;
        push_word(8'hEE);
        wait_drain(20);
        check("p5_rd_count_wrap", 32'(rd_count), 32'd0);

        // Random backpressure over 256 words.
        for (int i = 0; i < 256; i++) begin
            push_word(8'(i * 7 + 3));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            bus.data_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus.data_ready = 1'b1;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL p6_timeout: got %0d words left required 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
        #2;
        check("p6_rd_count", 32'(rd_count), 32'd256);
        check("p6_model_count", 32'(rd_count), 32'(exp_cnt));
        check("p6_idle", 32'(bus.data_valid), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
